// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: key codes, scan states and the matrix-to-code map.
package keypad_pkg;

  typedef enum logic [3:0] {
    K0      = 4'h0, K1 = 4'h1, K2 = 4'h2, K3 = 4'h3, K4 = 4'h4,
    K5      = 4'h5, K6 = 4'h6, K7 = 4'h7, K8 = 4'h8, K9 = 4'h9,
    K_ENTER = 4'hA,
    K_CLEAR = 4'hB,
    K_C     = 4'hC,
    K_D     = 4'hD,
    K_STAR  = 4'hE,
    K_HASH  = 4'hF
  } key_e;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_e;

  // Multiple low rows resolve to the lowest index.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic key_e key_at(input logic [1:0] row, input logic [1:0] col);
    key_e k;
    case ({row, col})
      4'h0: k = K1;      4'h1: k = K2;      4'h2: k = K3;      4'h3: k = K_ENTER;
      4'h4: k = K4;      4'h5: k = K5;      4'h6: k = K6;      4'h7: k = K_CLEAR;
      4'h8: k = K7;      4'h9: k = K8;      4'hA: k = K9;      4'hB: k = K_C;
      4'hC: k = K_STAR;  4'hD: k = K0;      4'hE: k = K_HASH;  default: k = K_D;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_entry_scanner_if.sv
// Keypad matrix pins plus the decoded key / operand outputs of the scanner.
interface keypad_entry_scanner_if;
  logic [3:0] row_sense;
  logic [3:0] col_drive;
  logic [3:0] key_code;
  logic       key_strobe;
  logic [7:0] entry;
  logic [1:0] digit_count;
  logic [7:0] value;
  logic       value_valid;

  modport slave (
    input  row_sense,
    output col_drive, key_code, key_strobe, entry, digit_count, value, value_valid
  );

  modport master (
    output row_sense,
    input  col_drive, key_code, key_strobe, entry, digit_count, value, value_valid
  );
endinterface

// File: rtl/decimal_accumulator.sv
// Builds an 8-bit operand from up to three decimal key presses; ENTER commits it, CLEAR drops it.
// Reacts in the key_strobe cycle; results are visible one cycle later.
module decimal_accumulator
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_strobe_i,
  input  logic [3:0] key_code_i,
  output logic [7:0] entry_o,
  output logic [1:0] digit_count_o,
  output logic [7:0] value_o,
  output logic       value_valid_o
);

  logic [7:0]  entry_q, entry_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  value_q, value_d;
  logic        valid_q, valid_d;
  logic [11:0] next_entry;

  // 255*10+9 fits in 12 bits, so overflow is judged before truncating.
  assign next_entry = 12'(entry_q) * 12'd10 + 12'(key_code_i);

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    value_d = value_q;
    valid_d = 1'b0;
    if (key_strobe_i) begin
      case (key_code_i)
        K_ENTER: begin
          if (count_q != 2'd0) begin
            value_d = entry_q;
            valid_d = 1'b1;
            entry_d = 8'd0;
            count_d = 2'd0;
          end
        end
        K_CLEAR: begin
          entry_d = 8'd0;
          count_d = 2'd0;
        end
        default: begin
          if (key_code_i <= 4'd9 && count_q < 2'd3 && next_entry <= 12'd255) begin
            entry_d = next_entry[7:0];
            count_d = count_q + 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= 8'd0;
      count_q <= 2'd0;
      value_q <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign entry_o       = entry_q;
  assign digit_count_o = count_q;
  assign value_o       = value_q;
  assign value_valid_o = valid_q;

endmodule

// File: rtl/keypad_entry_scanner.sv
// 4x4 keypad scanner: column rotation, row debounce on a prescaled tick, key decode,
// and a decimal accumulator that turns digit presses into an ALU operand.
module keypad_entry_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_entry_scanner_if.slave bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [3:0]  row_meta_q, row_s_q;
  logic [PW-1:0] presc_q, presc_d;
  logic        tick;
  scan_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  cap_q, cap_d;
  logic [1:0]  col_q, col_d;
  key_e        key_code_q, key_code_d;
  logic        key_strobe_q, key_strobe_d;

  assign tick = (presc_q == PW'(SCAN_DIV - 1));

  always_comb begin
    presc_d      = tick ? '0 : presc_q + 1'b1;
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_d        = cap_q;
    col_d        = col_q;
    key_code_d   = key_code_q;
    key_strobe_d = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (row_s_q == 4'hF) begin
            col_d = col_q + 2'd1;
          end else begin
            cap_d   = row_s_q;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (row_s_q != cap_q) begin
            state_d = SCAN;
          end else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
            key_code_d   = key_at(lowest_low_row(cap_q), col_q);
            key_strobe_d = 1'b1;
            cnt_d        = '0;
            state_d      = HELD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          // Any low row, including a second key, restarts the release count.
          if (row_s_q != 4'hF) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q   <= 4'hF;
      row_s_q      <= 4'hF;
      presc_q      <= '0;
      state_q      <= SCAN;
      cnt_q        <= '0;
      cap_q        <= 4'hF;
      col_q        <= 2'd0;
      key_code_q   <= K0;
      key_strobe_q <= 1'b0;
    end else begin
      row_meta_q   <= bus.row_sense;
      row_s_q      <= row_meta_q;
      presc_q      <= presc_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_q        <= cap_d;
      col_q        <= col_d;
      key_code_q   <= key_code_d;
      key_strobe_q <= key_strobe_d;
    end
  end

  assign bus.col_drive  = ~(4'b0001 << col_q);
  assign bus.key_code   = key_code_q;
  assign bus.key_strobe = key_strobe_q;

  decimal_accumulator u_acc (
    .clk           (clk),
    .rst           (rst),
    .key_strobe_i  (key_strobe_q),
    .key_code_i    (key_code_q),
    .entry_o       (bus.entry),
    .digit_count_o (bus.digit_count),
    .value_o       (bus.value),
    .value_valid_o (bus.value_valid)
  );

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Bench for keypad_entry_scanner with a behavioural 4x4 keypad and an arithmetic entry model.
module tb_keypad_entry_scanner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_entry_scanner_if kif();

  keypad_entry_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  // Keypad: the pressed key pulls its row low only while its column is driven low.
  logic       pressed = 1'b0;
  logic [1:0] key_r = 2'd0, key_c = 2'd0;
  always_comb begin
    kif.row_sense = 4'hF;
    if (pressed && kif.col_drive[key_c] == 1'b0) kif.row_sense[key_r] = 1'b0;
  end

  int layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int total = 0, bad = 0;
  int strobe_cnt = 0, valid_cnt = 0;
  logic [3:0] last_code = 4'h0;

  always @(negedge clk) begin
    if (kif.key_strobe === 1'b1) begin
      strobe_cnt++;
      last_code = kif.key_code;
    end
    if (kif.value_valid === 1'b1) valid_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_key(input int code);
    for (int i = 0; i < 16; i++) begin
      if (layout[i] == code) begin
        key_r = 2'(i / 4);
        key_c = 2'(i % 4);
      end
    end
  endtask

  task automatic press(input int code, input int hold, output int ns, output int nv);
    int s0, v0;
    s0 = strobe_cnt;
    v0 = valid_cnt;
    set_key(code);
    pressed = 1'b1;
    repeat (hold) @(negedge clk);
    pressed = 1'b0;
    repeat (24) @(negedge clk);
    ns = strobe_cnt - s0;
    nv = valid_cnt - v0;
  endtask

  task automatic chk_outputs(input string tag, input int e, input int c, input int v);
    chk({tag, "_entry"}, int'(kif.entry), e);
    chk({tag, "_count"}, int'(kif.digit_count), c);
    chk({tag, "_value"}, int'(kif.value), v);
  endtask

  typedef struct {
    int key;
    int entry;
    int cnt;
    int value;
    int vp;
  } vec_t;

  vec_t vecs [22];

  // Reference model state
  int m_entry, m_cnt, m_value, m_vp;

  task automatic model_key(input int k);
    m_vp = 0;
    if (k <= 9) begin
      if (m_cnt < 3 && m_entry * 10 + k <= 255) begin
        m_entry = m_entry * 10 + k;
        m_cnt++;
      end
    end else if (k == 10) begin
      if (m_cnt > 0) begin
        m_value = m_entry;
        m_vp    = 1;
        m_entry = 0;
        m_cnt   = 0;
      end
    end else if (k == 11) begin
      m_entry = 0;
      m_cnt   = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ns, nv, k, n, bound;
    logic [3:0] exp_col;

    vecs = '{
      '{5, 5, 1, 0, 0},    '{11, 0, 0, 0, 0},
      '{2, 2, 1, 0, 0},    '{5, 25, 2, 0, 0},   '{5, 255, 3, 0, 0},  '{10, 0, 0, 255, 1},
      '{2, 2, 1, 255, 0},  '{6, 26, 2, 255, 0}, '{0, 26, 2, 255, 0}, '{11, 0, 0, 255, 0},
      '{1, 1, 1, 255, 0},  '{2, 12, 2, 255, 0}, '{3, 123, 3, 255, 0},'{4, 123, 3, 255, 0},
      '{11, 0, 0, 255, 0}, '{10, 0, 0, 255, 0},
      '{4, 4, 1, 255, 0},  '{2, 42, 2, 255, 0}, '{11, 0, 0, 255, 0}, '{10, 0, 0, 255, 0},
      '{12, 0, 0, 255, 0}, '{15, 0, 0, 255, 0}
    };

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col", int'(kif.col_drive), 4'b1110);
    chk("rst_code", int'(kif.key_code), 0);
    chk("rst_strobe", int'(kif.key_strobe), 0);
    chk("rst_valid", int'(kif.value_valid), 0);
    chk_outputs("rst", 0, 0, 0);
    rst = 1'b0;

    // Idle rotation: column index advances every 4 clocks after reset.
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((n / 4) % 4));
      chk("idle_col", int'(kif.col_drive), int'(exp_col));
    end
    chk("idle_strobes", strobe_cnt, 0);
    chk("idle_valids", valid_cnt, 0);

    for (int i = 0; i < 22; i++) begin
      press(vecs[i].key, 40, ns, nv);
      chk("vec_strobes", ns, 1);
      chk("vec_code", int'(last_code), vecs[i].key);
      chk_outputs("vec", vecs[i].entry, vecs[i].cnt, vecs[i].value);
      chk("vec_valid_pulses", nv, vecs[i].vp);
    end

    // One-tick glitch on '5' must not be accepted.
    press(5, 4, ns, nv);
    chk("glitch_strobes", ns, 0);
    chk("glitch_entry", int'(kif.entry), 0);

    // Build entry=12, then reset while '7' is in debounce.
    press(1, 40, ns, nv);
    press(2, 40, ns, nv);
    chk("pre_rst_entry", int'(kif.entry), 12);
    bound = 0;
    while (kif.col_drive[0] == 1'b0 && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    set_key(7);
    pressed = 1'b1;
    while (kif.col_drive[0] != 1'b0 && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    chk("col0_wait_in_budget", int'(bound < 100), 1);
    ns = strobe_cnt;
    repeat (6) @(negedge clk);
    chk("debounce_no_strobe_yet", strobe_cnt - ns, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_col", int'(kif.col_drive), 4'b1110);
    chk("mid_rst_code", int'(kif.key_code), 0);
    chk("mid_rst_strobe", int'(kif.key_strobe), 0);
    chk("mid_rst_valid", int'(kif.value_valid), 0);
    chk_outputs("mid_rst", 0, 0, 0);
    rst = 1'b0;
    ns = strobe_cnt;
    repeat (40) @(negedge clk);
    pressed = 1'b0;
    repeat (24) @(negedge clk);
    chk("post_rst_strobes", strobe_cnt - ns, 1);
    chk("post_rst_code", int'(last_code), 7);
    chk_outputs("post_rst", 7, 1, 0);

    // Random key sequence against the arithmetic model.
    m_entry = 7; m_cnt = 1; m_value = 0; m_vp = 0;
    for (int i = 0; i < 40; i++) begin
      k = (i % 3 == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      press(k, 40, ns, nv);
      model_key(k);
      chk("rnd_strobes", ns, 1);
      chk("rnd_code", int'(last_code), k);
      chk_outputs("rnd", m_entry, m_cnt, m_value);
      chk("rnd_valid_pulses", nv, m_vp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
